// File: rtl/cdma_wt_rdreq_gen_if.sv
// DMA read-request and tracking-FIFO push signals for the CDMA weight read-request generator.
interface cdma_wt_rdreq_gen_if;
  logic        dma_rd_req_valid;
  logic        dma_rd_req_ready;
  logic [63:0] dma_rd_req_addr;
  logic [14:0] dma_rd_req_size;
  logic        fifo_wr_req;
  logic        fifo_wr_ready;
  logic [5:0]  fifo_wr_data;

  modport master (
    output dma_rd_req_valid, dma_rd_req_addr, dma_rd_req_size, fifo_wr_req, fifo_wr_data,
    input  dma_rd_req_ready, fifo_wr_ready
  );

  modport slave (
    input  dma_rd_req_valid, dma_rd_req_addr, dma_rd_req_size, fifo_wr_req, fifo_wr_data,
    output dma_rd_req_ready, fifo_wr_ready
  );
endinterface

// File: rtl/cdma_wt_rdreq_gen.sv
// Splits a weight-surface fetch into block-aligned DMA reads, pushing a tracking descriptor before each.
// Optional macro CDMA_WT_RDREQ_STALL_CNT_EN adds the stall_cnt backpressure counter output.
module cdma_wt_rdreq_gen #(
  parameter int REQ_MAX_ATOMS = 32
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        cfg_start,
  input  logic [63:0] cfg_base_addr,
  input  logic [31:0] cfg_atoms,
  output logic        busy,
  output logic        done,
  cdma_wt_rdreq_gen_if.master bus
`ifdef CDMA_WT_RDREQ_STALL_CNT_EN
  , output logic [31:0] stall_cnt
`endif
);

  localparam int BLK_W = (REQ_MAX_ATOMS > 1) ? $clog2(REQ_MAX_ATOMS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PUSH  = 2'd1,
    ISSUE = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] cur_addr_q, cur_addr_d;
  logic [31:0] rem_q, rem_d;
  logic [63:0] req_addr_q, req_addr_d;
  logic [4:0]  req_size_q, req_size_d;
  logic        req_last_q, req_last_d;

  logic [BLK_W-1:0] blk_off;
  logic [5:0]       room;
  logic [5:0]       push_n;
  logic             push_last;
  logic [5:0]       req_n;
  logic             fifo_wr_req;
  logic [5:0]       fifo_wr_data;
  logic             dma_valid;

  // Atoms left before the next REQ_MAX_ATOMS*32-byte boundary bound the request length.
  always_comb begin
    blk_off   = (REQ_MAX_ATOMS > 1) ? cur_addr_q[5 +: BLK_W] : '0;
    room      = 6'(REQ_MAX_ATOMS) - 6'(blk_off);
    push_n    = (rem_q < {26'b0, room}) ? rem_q[5:0] : room;
    push_last = (rem_q == {26'b0, push_n});
    req_n     = {1'b0, req_size_q} + 6'd1;
  end

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    rem_d        = rem_q;
    req_addr_d   = req_addr_q;
    req_size_d   = req_size_q;
    req_last_d   = req_last_q;
    fifo_wr_req  = 1'b0;
    fifo_wr_data = 6'd0;
    dma_valid    = 1'b0;
    done         = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          cur_addr_d = cfg_base_addr & ~64'h1F;
          rem_d      = cfg_atoms;
          state_d    = (cfg_atoms == 32'd0) ? FIN : PUSH;
        end
      end
      PUSH: begin
        fifo_wr_data = {push_last, 5'(push_n - 6'd1)};
        fifo_wr_req  = bus.fifo_wr_ready;
        if (bus.fifo_wr_ready) begin
          req_addr_d = cur_addr_q;
          req_size_d = 5'(push_n - 6'd1);
          req_last_d = push_last;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        dma_valid = 1'b1;
        if (bus.dma_rd_req_ready) begin
          cur_addr_d = cur_addr_q + {53'b0, req_n, 5'b0};
          rem_d      = rem_q - {26'b0, req_n};
          state_d    = req_last_q ? FIN : PUSH;
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      rem_q      <= '0;
      req_addr_q <= '0;
      req_size_q <= '0;
      req_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      rem_q      <= rem_d;
      req_addr_q <= req_addr_d;
      req_size_q <= req_size_d;
      req_last_q <= req_last_d;
    end
  end

  assign busy                 = (state_q != IDLE);
  assign bus.fifo_wr_req      = fifo_wr_req;
  assign bus.fifo_wr_data     = fifo_wr_data;
  assign bus.dma_rd_req_valid = dma_valid;
  assign bus.dma_rd_req_addr  = req_addr_q;
  assign bus.dma_rd_req_size  = {10'b0, req_size_q};

`ifdef CDMA_WT_RDREQ_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Counts cycles lost to FIFO-full or DMA backpressure, saturating.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == IDLE && cfg_start) begin
      stall_cnt_d = '0;
    end else if (((state_q == PUSH && !bus.fifo_wr_ready) ||
                  (state_q == ISSUE && !bus.dma_rd_req_ready)) &&
                 stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) stall_cnt_q <= '0;
    else         stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/cdma_wt_rdreq_gen.md
Name: cdma_wt_rdreq_gen

Overview:
Weight-path DMA read-request generator in CDMA, directly upstream of the 128x6 weight-request tracking FIFO.
- Splits one weight-surface fetch (base address plus atom count) into aligned DMA read requests.
- For every request, pushes a 6-bit descriptor into the tracking FIFO *before* issuing the request, so the response side always finds a descriptor waiting.
- Atom = 32 bytes.

Parameters:
- REQ_MAX_ATOMS, 32, max atoms per request; power of two, range 1..32; requests never cross a REQ_MAX_ATOMS*32-byte boundary.

Ports:
- clk  in  1  core clock
- reset_  in  1  asynchronous active-low reset
- cfg_start  in  1  start pulse; honoured only in IDLE, ignored otherwise
- cfg_base_addr  in  64  byte base address; bits[4:0] ignored (treated as 0)
- cfg_atoms  in  32  total atoms to fetch
- busy  out  1  high in any state other than IDLE
- done  out  1  1-cycle pulse when the job completes
- dma_rd_req_valid  out  1  request valid
- dma_rd_req_ready  in  1  request accept
- dma_rd_req_addr  out  64  request byte address, 32B aligned
- dma_rd_req_size  out  15  atoms-1
- fifo_wr_req  out  1  descriptor push to tracking FIFO
- fifo_wr_ready  in  1  FIFO can accept (registered inside the FIFO)
- fifo_wr_data  out  6  descriptor: [5]=last request of job, [4:0]=atoms-1

Behaviour:
- Reset values (async, active-low): all outputs 0, state IDLE, internal address and remaining counters 0.
- State IDLE:
  - cfg_start=1 latches cur_addr = {cfg_base_addr[63:5],5'b0} and rem = cfg_atoms.
  - rem=0 goes to FIN; otherwise goes to PUSH.
- State PUSH:
  - blk_off = cur_addr[5 +: log2(REQ_MAX_ATOMS)] (0 when REQ_MAX_ATOMS=1).
  - n = min(rem, REQ_MAX_ATOMS - blk_off).
  - last = (rem == n).
  - fifo_wr_req = fifo_wr_ready, combinational; fifo_wr_data = {last, n-1}.
  - On fifo_wr_req=1: register n, last and cur_addr into the request holding registers, then go to ISSUE.
  - While fifo_wr_ready=0: stay in PUSH and issue no push.
- State ISSUE:
  - dma_rd_req_valid=1, addr and size held stable until dma_rd_req_ready.
  - Valid never drops before accept.
  - On accept: cur_addr += n*32 (mod 2^64), rem -= n. Go to FIN if last, else PUSH.
- State FIN: done=1 for exactly one cycle, then IDLE.
- Latency:
  - Start to first fifo_wr_req: 1 cycle, if fifo_wr_ready=1.
  - fifo_wr_req to dma valid: 1 cycle.
  - With no backpressure, throughput is one request per 2 cycles.
- Ordering: exactly one FIFO push precedes each DMA request. Push count equals request count for every job.
- Constraints:
  - fifo_wr_req never asserts while fifo_wr_ready=0.
  - dma_rd_req_valid never asserts outside ISSUE.
- Jobs: cfg_start during busy is ignored. A new job may start in the cycle following the done pulse.
- Reset mid-operation: immediate return to IDLE. In-flight descriptors and requests are abandoned; the FIFO is reset on the same reset_.

Optional Feature:
- Macro: CDMA_WT_RDREQ_STALL_CNT_EN.
- With macro:
  - Adds output stall_cnt (32 bits).
  - Increments once per cycle in PUSH with fifo_wr_ready=0, and once per cycle in ISSUE with dma_rd_req_ready=0.
  - Saturates at 0xFFFFFFFF.
  - Cleared to 0 by reset_ and on an accepted cfg_start.
- Without macro: port and logic absent; the rest of the behaviour is identical.

Test Plan:
- base=0x1000, atoms=70, REQ_MAX_ATOMS=32, no backpressure:
  - descriptors 0x1F, 0x1F, 0x25;
  - requests (0x1000,31), (0x1400,31), (0x1800,5);
  - done 1 cycle after the 3rd accept.
- base=0x10E0 (blk_off=7), atoms=40:
  - descriptors 0x18, 0x2E;
  - requests (0x10E0,24), (0x1400,14).
- atoms=0: done one cycle after start; no fifo_wr_req; no dma_rd_req_valid.
- fifo_wr_ready held 0 for 10 cycles in PUSH:
  - no push, no valid during that window;
  - push on the first ready cycle;
  - stall_cnt=10 with the macro.
- dma_rd_req_ready held 0 for 5 cycles:
  - valid, addr and size stable throughout;
  - single accept;
  - exactly one descriptor pushed for that request.
- reset_ asserted during ISSUE of request 2 of a 70-atom job:
  - all outputs 0 immediately;
  - a new start with atoms=1 yields descriptor 0x20 and request (base,0).
